// File: rtl/fifo_frame_packer.sv
// fifo_frame_packer
//   Pulls 64-bit words from the read side of the 8-to-64 CDC FIFO and emits
//   one frame per start pulse on a 32-bit valid/ready stream:
//   header {HDR_TAG, seq}, then each word as two beats, high half first.
//   Optional macro FRAME_CHECKSUM_EN appends an XOR checksum beat.
//
// Parameters
//   FRAME_WORDS  64-bit words per frame (1..1023)
//   RD_LAT       fifo_rd_en to fifo_dout_vld latency in cycles (1..4)
//   HDR_TAG      upper 16 bits of the header beat
//
// Ports
//   rd_clk, rst_n          clock, synchronous active-low reset
//   start                  one-cycle frame request (ignored unless idle)
//   fifo_empty, fifo_dout, fifo_dout_vld, fifo_rd_en   FIFO read side
//   m_data, m_valid, m_ready, m_last                   output stream
//   busy, frame_done, ovf_err                          status
//
// State | meaning
//   IDLE  | waiting for start
//   HEAD  | presenting the header beat, prefetching words
//   DATA  | streaming buffered words, two beats per word
//   CSUM  | presenting the checksum beat (FRAME_CHECKSUM_EN only)
//   DONE  | one-cycle frame_done, seq advances

module fifo_frame_packer #(
    parameter int          FRAME_WORDS = 16,
    parameter int          RD_LAT      = 2,
    parameter logic [15:0] HDR_TAG     = 16'hA5A5
) (
    input  logic        rd_clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        fifo_empty,
    input  logic [63:0] fifo_dout,
    input  logic        fifo_dout_vld,
    output logic        fifo_rd_en,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic        busy,
    output logic        frame_done,
    output logic        ovf_err
);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("fifo_frame_packer: RD_LAT must be 1..4");
    end
    if (FRAME_WORDS < 1 || FRAME_WORDS > 1023) begin : g_bad_frame_words
        $error("fifo_frame_packer: FRAME_WORDS must be 1..1023");
    end

    localparam logic [9:0] FW    = 10'(FRAME_WORDS);
    localparam logic [9:0] FW_M1 = 10'(FRAME_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEAD,
        S_DATA,
`ifdef FRAME_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_t;

    state_t      state;
    logic [15:0] seq;
    logic [9:0]  rd_issued;
    logic [9:0]  words_sent;
    logic        half;          // 0: high beat of buf_q[0] next, 1: low beat
    logic [1:0]  inflight;
    logic [1:0]  buf_cnt;
    logic [63:0] buf_q [2];
`ifdef FRAME_CHECKSUM_EN
    logic [31:0] csum;
`endif

    logic xfer, pop, ret, push, wr_idx, rd_ok;

    // Stream outputs decode only registered state, so they cannot change
    // while a beat is stalled: a push only ever writes behind the head entry.
    always_comb begin
        m_valid = 1'b0;
        m_data  = '0;
        m_last  = 1'b0;
        unique case (state)
            S_HEAD: begin
                m_valid = 1'b1;
                m_data  = {HDR_TAG, seq};
            end
            S_DATA: begin
                m_valid = (buf_cnt != 2'd0);
                m_data  = half ? buf_q[0][31:0] : buf_q[0][63:32];
`ifndef FRAME_CHECKSUM_EN
                m_last  = (buf_cnt != 2'd0) && half && (words_sent == FW_M1);
`endif
            end
`ifdef FRAME_CHECKSUM_EN
            S_CSUM: begin
                m_valid = 1'b1;
                m_data  = csum;
                m_last  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign busy       = (state != S_IDLE);
    assign frame_done = (state == S_DONE);

    always_comb begin
        xfer   = m_valid && m_ready;
        pop    = (state == S_DATA) && xfer && half;
        // Returns are only accepted against an outstanding read; words that
        // were in flight across a reset arrive with inflight == 0 and vanish.
        ret    = fifo_dout_vld && (inflight != 2'd0);
        push   = ret && (buf_cnt != 2'd2);
        wr_idx = (buf_cnt == 2'd1) && !pop;
        // Reads are never issued back to back, so fifo_empty seen this cycle
        // already reflects the previous read and rd_en never meets an empty FIFO.
        rd_ok  = ((state == S_HEAD) || (state == S_DATA)) && !fifo_rd_en &&
                 (rd_issued < FW) && !fifo_empty &&
                 (({1'b0, inflight} + {1'b0, buf_cnt}) < 3'd2);
    end

    always_ff @(posedge rd_clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            seq        <= '0;
            rd_issued  <= '0;
            words_sent <= '0;
            half       <= 1'b0;
            inflight   <= '0;
            buf_cnt    <= '0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            ovf_err    <= 1'b0;
            fifo_rd_en <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            fifo_rd_en <= rd_ok;
            if (fifo_rd_en) rd_issued <= rd_issued + 10'd1;

            unique case ({fifo_rd_en, ret})
                2'b10:   inflight <= inflight + 2'd1;
                2'b01:   inflight <= inflight - 2'd1;
                default: ;
            endcase

            if (pop) buf_q[0] <= buf_q[1];
            if (push) buf_q[wr_idx] <= fifo_dout;
            unique case ({push, pop})
                2'b10:   buf_cnt <= buf_cnt + 2'd1;
                2'b01:   buf_cnt <= buf_cnt - 2'd1;
                default: ;
            endcase
            if (ret && (buf_cnt == 2'd2)) ovf_err <= 1'b1;

            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_HEAD;
                        rd_issued  <= '0;
                        words_sent <= '0;
                        half       <= 1'b0;
                    end
                end
                S_HEAD: begin
`ifdef FRAME_CHECKSUM_EN
                    csum <= '0;
`endif
                    if (xfer) state <= S_DATA;
                end
                S_DATA: begin
                    if (xfer) begin
`ifdef FRAME_CHECKSUM_EN
                        csum <= csum ^ m_data;
`endif
                        half <= !half;
                        if (half) begin
                            words_sent <= words_sent + 10'd1;
                            if (words_sent == FW_M1) begin
`ifdef FRAME_CHECKSUM_EN
                                state <= S_CSUM;
`else
                                state <= S_DONE;
`endif
                            end
                        end
                    end
                end
`ifdef FRAME_CHECKSUM_EN
                S_CSUM: begin
                    if (xfer) state <= S_DONE;
                end
`endif
                S_DONE: begin
                    seq   <= seq + 16'd1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_frame_packer.sv
// tb_fifo_frame_packer
//   Randomized bench for fifo_frame_packer. A queue-based FIFO with a fixed
//   read latency feeds the DUT; the reference frame is rebuilt from the words
//   the FIFO handed out (header, word halves high first, optional checksum).
//   Build with FRAME_CHECKSUM_EN defined to cover the checksum variant.

module tb_fifo_frame_packer;

    localparam int          FW  = 2;
    localparam int          LAT = 2;
    localparam logic [15:0] TAG = 16'hA5A5;
`ifdef FRAME_CHECKSUM_EN
    localparam int NB = 2 * FW + 2;
`else
    localparam int NB = 2 * FW + 1;
`endif

    logic        rd_clk;
    logic        rst_n;
    logic        start;
    logic        fifo_empty;
    logic [63:0] fifo_dout;
    logic        fifo_dout_vld;
    logic        fifo_rd_en;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic        busy;
    logic        frame_done;
    logic        ovf_err;

    fifo_frame_packer #(
        .FRAME_WORDS(FW),
        .RD_LAT     (LAT),
        .HDR_TAG    (TAG)
    ) dut (
        .rd_clk       (rd_clk),
        .rst_n        (rst_n),
        .start        (start),
        .fifo_empty   (fifo_empty),
        .fifo_dout    (fifo_dout),
        .fifo_dout_vld(fifo_dout_vld),
        .fifo_rd_en   (fifo_rd_en),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_last       (m_last),
        .busy         (busy),
        .frame_done   (frame_done),
        .ovf_err      (ovf_err)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // FIFO model
    logic [63:0] fifo_q [$];
    logic [63:0] pops   [$];
    logic [63:0] dl_d   [LAT];
    bit          dl_v   [LAT];
    bit          rd_s;
    int          rdy_mode = 0;
    int          rdy_ph   = 0;
    bit [3:0]    rdy_pat  = 4'b1001;

    // Reference frame state
    logic [15:0] m_seq;
    int          beat;
    int          rd_cnt;
    int          done_seen;
    logic [31:0] mcsum;
    bit          done_pending;
    bit          stall_prev;
    logic [31:0] prev_data;
    logic        prev_last;

    always @(posedge rd_clk) begin
        logic [63:0] w;
        #1;
        for (int i = LAT - 1; i > 0; i--) begin
            dl_v[i] = dl_v[i-1];
            dl_d[i] = dl_d[i-1];
        end
        dl_v[0] = 1'b0;
        dl_d[0] = '0;
        if (rd_s && fifo_q.size() > 0) begin
            w = fifo_q.pop_front();
            dl_v[0] = 1'b1;
            dl_d[0] = w;
            pops.push_back(w);
        end
        fifo_dout_vld = dl_v[LAT-1];
        fifo_dout     = dl_d[LAT-1];
        fifo_empty    = (fifo_q.size() == 0);
        case (rdy_mode)
            1:       begin m_ready = rdy_pat[rdy_ph % 4]; rdy_ph++; end
            2:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b1;
        endcase
    end

    always @(negedge rd_clk) begin
        logic [31:0] exp_d;
        logic [63:0] w;
        int          idx;
        rd_s = fifo_rd_en;
        if (rst_n) begin
            if (fifo_rd_en) begin
                chk("rd_while_empty", fifo_empty, 1'b0);
                rd_cnt++;
            end
            if (stall_prev) begin
                chk("stall_valid", m_valid, 1'b1);
                chk("stall_data", m_data, prev_data);
                chk("stall_last", m_last, prev_last);
            end
            if (done_pending || frame_done) chk("frame_done", frame_done, done_pending);
            if (done_pending) begin
                done_seen++;
                m_seq = m_seq + 16'd1;
            end
            done_pending = 1'b0;
            if (m_valid && m_ready) begin
                if (beat >= NB) begin
                    chk("extra_beat", m_valid, 1'b0);
                end else begin
                    exp_d = 32'h0;
                    if (beat == 0) begin
                        exp_d = {TAG, m_seq};
                    end else if (beat <= 2 * FW) begin
                        idx = (beat - 1) / 2;
                        if (pops.size() <= idx) begin
                            chk("beat_before_read", pops.size(), idx + 1);
                        end else begin
                            w     = pops[idx];
                            exp_d = ((beat - 1) % 2 == 0) ? w[63:32] : w[31:0];
                        end
                        mcsum = mcsum ^ exp_d;
                    end else begin
                        exp_d = mcsum;
                    end
                    chk($sformatf("beat%0d_data", beat), m_data, exp_d);
                    chk($sformatf("beat%0d_last", beat), m_last, (beat == NB - 1));
                    if (beat == NB - 1) done_pending = 1'b1;
                    beat++;
                end
            end
            stall_prev = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end else begin
            stall_prev   = 1'b0;
            done_pending = 1'b0;
        end
    end

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic push_word(input logic [63:0] w);
        @(negedge rd_clk);
        fifo_q.push_back(w);
    endtask

    task automatic push_random(input int n);
        for (int i = 0; i < n; i++) push_word({$urandom, $urandom});
    endtask

    task automatic do_start();
        tick();
        pops.delete();
        beat   = 0;
        mcsum  = '0;
        rd_cnt = 0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic finish_frame(input string name, input int target);
        int k = 0;
        while (done_seen < target && k < 400) begin
            @(negedge rd_clk);
            k++;
        end
        if (done_seen < target) chk({name, "_timeout"}, done_seen, target);
        chk({name, "_beats"}, beat, NB);
        chk({name, "_rd_count"}, rd_cnt, FW);
        chk({name, "_ovf"}, ovf_err, 1'b0);
        tick();
    endtask

    task automatic run_frame(input string name, input bit extra_start);
        int target;
        target = done_seen + 1;
        do_start();
        if (extra_start) begin
            repeat (2) tick();
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        finish_frame(name, target);
    endtask

    task automatic check_quiet(input string name);
        @(negedge rd_clk);
        chk({name, "_m_valid"}, m_valid, 1'b0);
        chk({name, "_m_data"}, m_data, 32'h0);
        chk({name, "_m_last"}, m_last, 1'b0);
        chk({name, "_rd_en"}, fifo_rd_en, 1'b0);
        chk({name, "_busy"}, busy, 1'b0);
        chk({name, "_frame_done"}, frame_done, 1'b0);
        chk({name, "_ovf"}, ovf_err, 1'b0);
    endtask

    initial begin
        int target;
        int k;
        rst_n         = 1'b0;
        start         = 1'b0;
        fifo_empty    = 1'b1;
        fifo_dout     = '0;
        fifo_dout_vld = 1'b0;
        m_ready       = 1'b1;
        m_seq         = '0;
        beat          = 0;
        rd_cnt        = 0;
        done_seen     = 0;
        mcsum         = '0;
        rd_s          = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            dl_v[i] = 1'b0;
            dl_d[i] = '0;
        end
        repeat (3) tick();
        check_quiet("reset");
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Basic frame with the reference words
        rdy_mode = 0;
        push_word(64'h0011223344556677);
        push_word(64'h8899AABBCCDDEEFF);
        repeat (2) tick();
        run_frame("basic", 1'b0);

        // Backpressure pattern 1,0,0,1
        rdy_mode = 1;
        rdy_ph   = 0;
        push_word(64'h0011223344556677);
        push_word(64'h8899AABBCCDDEEFF);
        repeat (2) tick();
        run_frame("bp", 1'b0);

        // Starvation: only one word available for a while
        rdy_mode = 0;
        push_random(1);
        repeat (2) tick();
        target = done_seen + 1;
        do_start();
        repeat (12) tick();
        @(negedge rd_clk);
        chk("gap_m_valid", m_valid, 1'b0);
        chk("gap_rd_en", fifo_rd_en, 1'b0);
        chk("gap_busy", busy, 1'b1);
        chk("gap_beats", beat, 3);
        repeat (8) tick();
        push_random(FW - 1);
        finish_frame("starve", target);

        // Random backpressure and data
        rdy_mode = 2;
        for (int f = 0; f < 4; f++) begin
            push_random(FW);
            repeat (2) tick();
            run_frame($sformatf("rand%0d", f), 1'b0);
        end

        // Sequence wrap with ignored start pulses while busy
        tick();
        force dut.seq = 16'hFFFE;
        tick();
        release dut.seq;
        m_seq = 16'hFFFE;
        for (int f = 0; f < 3; f++) begin
            push_random(FW);
            repeat (2) tick();
            run_frame($sformatf("wrap%0d", f), 1'b1);
        end

        // Reset in the middle of the data phase
        rdy_mode = 0;
        push_random(FW);
        repeat (2) tick();
        do_start();
        k = 0;
        while (beat < 3 && k < 200) begin
            @(negedge rd_clk);
            k++;
        end
        if (beat < 3) chk("midreset_reach_beat3", beat, 3);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_seq = '0;
        beat  = 0;
        check_quiet("midreset");
        repeat (LAT + 4) tick();
        fifo_q.delete();
        push_random(FW);
        repeat (2) tick();
        run_frame("after_reset", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
